// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and bus widths for the instruction/data memory arbiter.
//   CORE_ADDR_BUS_W / CORE_DATA_BUS : core-wide word-address and data widths
//   AW / DW                         : arbiter aliases of the above
//   arb_rsp_t                       : response FSM states
//   arb_src_t                       : requester identity (last-grant register)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int CORE_ADDR_BUS_W = 14;
  localparam int CORE_DATA_BUS   = 32;

  localparam int AW   = CORE_ADDR_BUS_W;
  localparam int DW   = CORE_DATA_BUS;
  localparam int WE_W = DW / 8;

  // Bit positions of each requester inside the req/gnt vectors.
  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } arb_rsp_t;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } arb_src_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// Valid/ready bus interfaces used by mem_arbiter.
//   rv_if_da : request channel with address and data
//              (valid, addr, data : TX -> RX; ready : RX -> TX)
//   rv_if    : data-only channel
//              (valid, data : TX -> RX; ready : RX -> TX)
// -----------------------------------------------------------------------------
interface rv_if_da
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = CORE_ADDR_BUS_W,
  parameter int DATA_W = CORE_DATA_BUS
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport TX (output valid, addr, data, input  ready);
  modport RX (input  valid, addr, data, output ready);
endinterface

interface rv_if
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_BUS
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport TX (output valid, data, input  ready);
  modport RX (input  valid, data, output ready);
endinterface

// File: rtl/mem_arbiter_pick2.sv
// -----------------------------------------------------------------------------
// arb_pick2
// Two-input grant picker for mem_arbiter.
//   clk, rst : clock / synchronous active-high reset (last-grant register only)
//   req[1:0] : request vector, bit REQ_I = imem, bit REQ_D = dmem
//   gnt[1:0] : one-hot grant (all-zero when nothing is requested)
// Build option MEM_ARB_RR_EN: ties alternate round-robin using a last-grant
// register (reset value imem, so dmem wins the first tie). Without it, dmem
// always wins ties and no state is kept.
// -----------------------------------------------------------------------------
module arb_pick2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic w_tie;
  assign w_tie = &req;

`ifdef MEM_ARB_RR_EN
  arb_src_t r_last_gnt;

  // NOTE: every output gets a default before the if, so no latch is inferred.
  always_comb begin
    gnt = req;
    if (w_tie) begin
      gnt = (r_last_gnt == SRC_IMEM) ? 2'b10 : 2'b01;
    end
  end

  // Only tied cycles move the priority; uncontested grants leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= SRC_IMEM;
    end else if (w_tie) begin
      r_last_gnt <= gnt[REQ_D] ? SRC_DMEM : SRC_IMEM;
    end
  end
`else
  always_comb begin
    gnt = req;
    if (w_tie) begin
      gnt = 2'b10;
    end
  end

  // Fixed priority keeps no state; clk/rst are only there for port parity.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port SRAM between an instruction-fetch port and a data
// load/store port, one access per cycle.
//   clk, rst        : clock / synchronous active-high reset
//   imem_req (RX)   : fetch request (addr; data ignored)
//   imem_rsp (TX)   : fetch read data, 1 cycle after grant (ready ignored)
//   dmem_req (RX)   : load/store request (addr, write data)
//   dmem_we         : byte strobes for dmem_req, all-zero = load
//   dmem_rsp (TX)   : load read data, 1 cycle after grant (ready ignored)
//   mem_en/we/addr/wdata : SRAM command, driven in the grant cycle
//   mem_rdata       : SRAM read data, valid 1 cycle after a read enable
//   imem_stall_cnt  : saturating count of cycles imem waited
// Build option MEM_ARB_RR_EN: round-robin tie break (see arb_pick2).
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  rv_if_da.RX             imem_req,
  rv_if.TX                imem_rsp,
  rv_if_da.RX             dmem_req,
  input  logic [WE_W-1:0] dmem_we,
  rv_if.TX                dmem_rsp,
  output logic            mem_en,
  output logic [WE_W-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [15:0]     imem_stall_cnt
);

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_dmem_store;
  arb_rsp_t   r_rsp_state;
  logic [15:0] r_stall_cnt;

  // Masking requests during reset forces readys, grants and mem_en low.
  assign w_req        = rst ? 2'b00 : {dmem_req.valid, imem_req.valid};
  assign w_dmem_store = (dmem_we != '0);

  arb_pick2 u_pick (
    .clk (clk),
    .rst (rst),
    .req (w_req),
    .gnt (w_gnt)
  );

  // Ready is the grant itself, so it can never rise without the matching valid.
  assign imem_req.ready = w_gnt[REQ_I];
  assign dmem_req.ready = w_gnt[REQ_D];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt[REQ_D]) begin
      mem_en    = 1'b1;
      mem_we    = dmem_we;
      mem_addr  = dmem_req.addr;
      mem_wdata = dmem_req.data;
    end else if (w_gnt[REQ_I]) begin
      mem_en    = 1'b1;
      mem_addr  = imem_req.addr;
    end
  end

  // Response FSM: remembers who owns the read data arriving next cycle.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_state <= RSP_NONE;
    end else if (w_gnt[REQ_I]) begin
      r_rsp_state <= RSP_I;
    end else if (w_gnt[REQ_D] && !w_dmem_store) begin
      r_rsp_state <= RSP_D;
    end else begin
      r_rsp_state <= RSP_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (imem_req.valid && !w_gnt[REQ_I] && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Gating with rst blanks a response whose grant came the cycle before reset.
  assign imem_rsp.valid = (r_rsp_state == RSP_I) && !rst;
  assign dmem_rsp.valid = (r_rsp_state == RSP_D) && !rst;
  assign imem_rsp.data  = imem_rsp.valid ? mem_rdata : '0;
  assign dmem_rsp.data  = dmem_rsp.valid ? mem_rdata : '0;
  assign imem_stall_cnt = rst ? 16'd0 : r_stall_cnt;

  // Fetch write data and both response readys have no function here.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{imem_req.data, imem_rsp.ready, dmem_rsp.ready};

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a behavioural SRAM, a shadow memory and
// grant model, and a response scoreboard filled in the grant cycle and drained
// one cycle later. Tie expectations follow MEM_ARB_RR_EN when defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [WE_W-1:0] dmem_we;
  logic            mem_en;
  logic [WE_W-1:0] mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [15:0]     imem_stall_cnt;

  always #5 clk = ~clk;

  rv_if_da imem_req ();
  rv_if    imem_rsp ();
  rv_if_da dmem_req ();
  rv_if    dmem_rsp ();

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_rsp       (imem_rsp),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_rsp       (dmem_rsp),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .imem_stall_cnt (imem_stall_cnt)
  );

  // Behavioural single-port SRAM with one cycle read latency.
  logic [DW-1:0] sram   [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == '0) begin
        mem_rdata <= sram[mem_addr];
      end else begin
        for (int b = 0; b < WE_W; b++) begin
          if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t sb_q [$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_stall  = 0;
  logic        m_last_imem = 1'b1;
  logic [1:0]  obs_gnt;
  logic [15:0] obs_stall;
  logic [DW-1:0] obs_d_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One arbitration cycle: drive at negedge, check previous responses and the
  // combinational grant, then advance the model.
  task automatic step(input logic iv, input logic [AW-1:0] ia,
                      input logic dv, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd, input logic [WE_W-1:0] dwe);
    logic eg_i, eg_d;
    rsp_t r;
    @(negedge clk);
    rst            = 1'b0;
    imem_req.valid = iv;
    imem_req.addr  = ia;
    imem_req.data  = $urandom;
    dmem_req.valid = dv;
    dmem_req.addr  = da;
    dmem_req.data  = dwd;
    dmem_we        = dwe;
    #2;
    obs_gnt    = {dmem_req.ready, imem_req.ready};
    obs_stall  = imem_stall_cnt;
    obs_d_data = dmem_rsp.data;

    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      check("rsp_i_valid", imem_rsp.valid, !r.is_d);
      check("rsp_d_valid", dmem_rsp.valid, r.is_d);
      check("rsp_data", r.is_d ? dmem_rsp.data : imem_rsp.data, r.data);
    end else begin
      check("rsp_i_idle", imem_rsp.valid, 1'b0);
      check("rsp_d_idle", dmem_rsp.valid, 1'b0);
    end
    check("stall_cnt", imem_stall_cnt, m_stall);

    eg_i = 1'b0;
    eg_d = 1'b0;
    if (iv && dv) begin
`ifdef MEM_ARB_RR_EN
      if (m_last_imem) eg_d = 1'b1;
      else             eg_i = 1'b1;
      m_last_imem = eg_i;
`else
      eg_d = 1'b1;
`endif
    end else begin
      eg_i = iv;
      eg_d = dv;
    end

    check("imem_ready", imem_req.ready, eg_i);
    check("dmem_ready", dmem_req.ready, eg_d);
    check("mem_en", mem_en, eg_i | eg_d);
    check("mem_we", mem_we, eg_d ? dwe : 4'b0000);
    if (eg_d) begin
      check("mem_addr_d", mem_addr, da);
      check("mem_wdata", mem_wdata, dwd);
    end else if (eg_i) begin
      check("mem_addr_i", mem_addr, ia);
    end

    if (eg_i) sb_q.push_back('{is_d: 1'b0, data: shadow[ia]});
    if (eg_d) begin
      if (dwe == '0) sb_q.push_back('{is_d: 1'b1, data: shadow[da]});
      else begin
        for (int b = 0; b < WE_W; b++)
          if (dwe[b]) shadow[da][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    if (iv && !eg_i && m_stall < 65535) m_stall++;
  endtask

  task automatic do_reset(input int n, input logic keep_valid);
    sb_q.delete();
    repeat (n) begin
      @(negedge clk);
      rst            = 1'b1;
      imem_req.valid = keep_valid;
      imem_req.addr  = 14'h0010;
      dmem_req.valid = keep_valid;
      dmem_req.addr  = 14'h0020;
      dmem_req.data  = 32'hFFFF_FFFF;
      dmem_we        = 4'b1111;
      #2;
      check("rst_imem_ready", imem_req.ready, 1'b0);
      check("rst_dmem_ready", dmem_req.ready, 1'b0);
      check("rst_rsp_valid", {imem_rsp.valid, dmem_rsp.valid}, 2'b00);
      check("rst_rsp_data", imem_rsp.data | dmem_rsp.data, 32'h0);
      check("rst_mem_cmd", {mem_en, mem_we}, 5'b0);
      check("rst_mem_addr", mem_addr, 14'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_stall", imem_stall_cnt, 16'h0);
    end
    m_stall     = 0;
    m_last_imem = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]   = 32'h9E37_79B9 * i;
      shadow[i] = 32'h9E37_79B9 * i;
    end
    sram[14'h0010] = 32'hDEAD_BEEF;  shadow[14'h0010] = 32'hDEAD_BEEF;
    sram[14'h0020] = 32'hAAAA_AAAA;  shadow[14'h0020] = 32'hAAAA_AAAA;

    rst = 1'b1;
    imem_req.valid = 1'b0; imem_req.addr = '0; imem_req.data = '0;
    dmem_req.valid = 1'b0; dmem_req.addr = '0; dmem_req.data = '0;
    dmem_we = '0;
    imem_rsp.ready = 1'b1;
    dmem_rsp.ready = 1'b1;
    @(posedge clk);
    do_reset(2, 1'b1);

    // Nothing requested.
    idle();

    // Single fetch: grant at N, DEADBEEF at N+1 for one cycle only.
    step(1'b1, 14'h0010, 1'b0, '0, '0, '0);
    check("fetch_grant", obs_gnt, 2'b01);
    idle();
    idle();

    // Back-to-back single-requester traffic, one access per cycle.
    for (int k = 0; k < 8; k++) begin
      if (k[0]) step(1'b1, 14'(k), 1'b0, '0, '0, '0);
      else      step(1'b0, '0, 1'b1, 14'(k + 100), '0, '0);
    end

    // Partial store then load of the same word.
    step(1'b0, '0, 1'b1, 14'h0020, 32'h1234_5678, 4'b0011);
    step(1'b0, '0, 1'b1, 14'h0020, 32'h0, 4'b0000);
    idle();
    check("merge_rd", obs_d_data, 32'hAAAA_5678);

    // Tie behaviour from a fresh reset.
    do_reset(1, 1'b0);
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 14'(k + 64), 1'b1, 14'(k + 80), '0, '0);
      check("rr_order", obs_gnt, k[0] ? 2'b01 : 2'b10);
    end
    idle();
`else
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 14'(k + 64), 1'b1, 14'(k + 80), '0, '0);
      check("tie_fixed", obs_gnt, 2'b10);
    end
    step(1'b1, 14'h0040, 1'b0, '0, '0, '0);
    check("tie_imem_after", obs_gnt, 2'b01);
    check("stall3", obs_stall, 16'd3);
    idle();
`endif

    // Mixed random traffic on a small address window.
    for (int k = 0; k < 200; k++) begin
      logic [WE_W-1:0] we;
      we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      step(1'($urandom), 14'($urandom_range(0, 63)),
           1'($urandom), 14'($urandom_range(0, 63)), $urandom, we);
    end
    idle();

    // Reset the cycle after a fetch grant: that response must never appear.
    step(1'b1, 14'h0010, 1'b0, '0, '0, '0);
    check("pre_rst_grant", obs_gnt, 2'b01);
    do_reset(2, 1'b0);
    idle();
    idle();

`ifndef MEM_ARB_RR_EN
    // Saturation of the stall counter under continuous dmem priority.
    do_reset(1, 1'b0);
    for (int k = 0; k < 65540; k++) begin
      step(1'b1, 14'h0001, 1'b1, 14'h0002, '0, '0);
    end
    check("stall_sat", obs_stall, 16'hFFFF);
    idle();
`endif

    idle();
    idle();
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
